tree_loader: RTL and testbench
==============================

TREE_LOADER -- requirements
Module: tree_loader

Interface
REQ-001 Parameter LEVEL, default 4, address width; DEPTH = 2**LEVEL node words.
REQ-002 Parameter DATA_WIDTH, default 16, node word width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
REQ-006 in_valid  input  1  node word available on in_data.
REQ-007 in_data  input  DATA_WIDTH  node word, sent in address order 0..DEPTH-1.
REQ-008 in_ready  output  1  loader accepts in_data this cycle.
REQ-009 bram_wen  output  1  write enable to the tree memory write port.
REQ-010 bram_addrW  output  LEVEL  write address.
REQ-011 bram_din  output  DATA_WIDTH  write data.
REQ-012 bram_addrR  output  LEVEL  read address for readback.
REQ-013 bram_dout  input  DATA_WIDTH  read data, valid one cycle after bram_addrR.
REQ-014 busy  output  1  high in LOAD and VERIFY.
REQ-015 done  output  1  high in DONE until next accepted start.
REQ-016 pass  output  1  readback checksum matched; meaningful only while done=1.

Function
REQ-017 FSM states: IDLE, LOAD, VERIFY, DONE.
REQ-018 IDLE/DONE -> LOAD on start=1; clears write counter, load checksum, verify checksum, done, pass.
REQ-019 LOAD: in_ready=1; a beat is in_valid&&in_ready.
REQ-020 On a beat: bram_wen=1, bram_addrW=write counter, bram_din=in_data, same cycle (combinational from in_data/in_valid, registered counter).
REQ-021 On a beat: load checksum <= load checksum XOR in_data; write counter increments.
REQ-022 Beat at counter DEPTH-1 -> VERIFY next cycle; counter wraps to 0; no further beats accepted.
REQ-023 in_valid=0 in LOAD: no write, no counter change; gaps of any length allowed.
REQ-024 Outside LOAD: in_ready=0, bram_wen=0.
REQ-025 VERIFY: bram_addrR steps 0..DEPTH-1, one address per cycle from VERIFY entry.
REQ-026 VERIFY: bram_dout captured the cycle after each address; verify checksum XORs each of the DEPTH captured words.
REQ-027 VERIFY lasts exactly DEPTH+1 cycles; then -> DONE with pass = (verify checksum == load checksum).
REQ-028 DONE: done=1, pass held, busy=0; stays until start.
REQ-029 start during LOAD or VERIFY ignored; no state change.
REQ-030 Latency: final beat to done=1 is DEPTH+2 cycles.
REQ-031 bram_addrR = 0 outside VERIFY.

Reset
REQ-032 rst=0 asynchronously forces IDLE; counters, checksums 0; in_ready, bram_wen, busy, done, pass = 0; bram_addrW, bram_addrR, bram_din = 0.
REQ-033 Reset mid-LOAD or mid-VERIFY abandons the operation; memory contents undefined; no done pulse on release.
REQ-034 First start honoured on the first rising edge after rst deasserts.

Structure
REQ-035 FSM state encoding and DEPTH derivation in shared package tree_pkg; LEVEL/DATA_WIDTH remain module parameters.
REQ-036 No sub-module; tree memory (bram_dp) instantiated outside, loader drives its write port and read port.
REQ-037 Checksum registers DATA_WIDTH wide; counters LEVEL+1 bits or LEVEL bits with explicit terminal detect.

Verification
REQ-038 LEVEL=4, start, 16 back-to-back beats data 0x0001..0x0010 -> 16 writes to addr 0..15, done after 18 further cycles, pass=1.
REQ-039 Same data, in_valid toggled every other cycle -> identical memory contents, writes only on valid cycles, pass=1.
REQ-040 Bench memory model corrupts addr 7 (flip bit 0) after write -> pass=0, done=1.
REQ-041 start pulsed during LOAD at beat 5 -> ignored, counter continues to 15, pass=1.
REQ-042 rst=0 after beat 9 -> all outputs 0 immediately; new start then 16 beats of 0xA5A5 -> pass=1.
REQ-043 start in DONE -> done, pass cleared next cycle, busy=1, in_ready=1.

Source files
------------

// File: rtl/tree_pkg.sv
// Shared definitions for the tree memory loader: FSM encoding and
// derivation of the node-word count from the address width.
package tree_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_LOAD   = 2'd1;
    localparam state_t ST_VERIFY = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    function automatic int unsigned tree_depth(input int unsigned level);
        return 32'd1 << level;
    endfunction

endpackage

// File: rtl/tree_loader.sv
// Streams DEPTH node words into the tree memory write port, then reads the
// memory back and compares an XOR checksum of the readback with the load.
//
// state  | meaning
// IDLE   | waiting for start after reset
// LOAD   | accepting node words, one write per beat
// VERIFY | sweeping the read port, folding readback into the checksum
// DONE   | result held on pass, waiting for the next start
module tree_loader
    import tree_pkg::*;
#(
    parameter int LEVEL      = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  bram_wen,
    output logic [LEVEL-1:0]      bram_addrW,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic [LEVEL-1:0]      bram_addrR,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic                  busy,
    output logic                  done,
    output logic                  pass
);

    localparam int unsigned      DEPTH       = tree_depth(LEVEL);
    localparam logic [LEVEL-1:0] LAST_ADDR   = '1;
    localparam logic [LEVEL:0]   VERIFY_LAST = (LEVEL+1)'(DEPTH);

    state_t                state;
    logic [LEVEL-1:0]      wr_cnt;
    logic [LEVEL:0]        vf_cnt;
    logic [DATA_WIDTH-1:0] ld_sum;
    logic [DATA_WIDTH-1:0] vf_sum;
    logic                  pass_r;
    logic                  beat;
    logic                  start_ok;

    assign in_ready = (state == ST_LOAD);
    assign beat     = in_ready & in_valid;
    assign start_ok = start & ((state == ST_IDLE) | (state == ST_DONE));

    assign bram_wen   = beat;
    assign bram_addrW = wr_cnt;
    assign bram_din   = beat ? in_data : '0;
    // vf_cnt[LEVEL] is only set on the final VERIFY cycle, after the last address
    assign bram_addrR = ((state == ST_VERIFY) && !vf_cnt[LEVEL]) ? vf_cnt[LEVEL-1:0] : '0;

    assign busy = (state == ST_LOAD) | (state == ST_VERIFY);
    assign done = (state == ST_DONE);
    assign pass = pass_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            wr_cnt <= '0;
            vf_cnt <= '0;
            ld_sum <= '0;
            vf_sum <= '0;
            pass_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state  <= ST_LOAD;
                        wr_cnt <= '0;
                        vf_cnt <= '0;
                        ld_sum <= '0;
                        vf_sum <= '0;
                        pass_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (beat) begin
                        ld_sum <= ld_sum ^ in_data;
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == LAST_ADDR) begin
                            state  <= ST_VERIFY;
                            vf_cnt <= '0;
                        end
                    end
                end
                ST_VERIFY: begin
                    vf_cnt <= vf_cnt + 1'b1;
                    // read data lags its address by one cycle, so cycle 0 has nothing to fold
                    if (vf_cnt != '0) begin
                        vf_sum <= vf_sum ^ bram_dout;
                    end
                    if (vf_cnt == VERIFY_LAST) begin
                        state  <= ST_DONE;
                        pass_r <= ((vf_sum ^ bram_dout) == ld_sum);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tree_loader.sv
// Scoreboard bench for tree_loader with a one-cycle-latency memory model
// that can corrupt address 7 on write.
module tb_tree_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        bram_wen;
    logic [3:0]  bram_addrW;
    logic [15:0] bram_din;
    logic [3:0]  bram_addrR;
    logic [15:0] bram_dout;
    logic        busy;
    logic        done;
    logic        pass;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] mem [16];
    logic [15:0] rd_q;
    logic        corrupt;
    logic        mem_clr;
    logic [15:0] words [16];
    logic [19:0] exp_wr [$];
    logic [19:0] wr_e;

    tree_loader #(.LEVEL(4), .DATA_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .bram_wen   (bram_wen),
        .bram_addrW (bram_addrW),
        .bram_din   (bram_din),
        .bram_addrR (bram_addrR),
        .bram_dout  (bram_dout),
        .busy       (busy),
        .done       (done),
        .pass       (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int a = 0; a < 16; a++) mem[a] <= 16'h0000;
        end else if (bram_wen) begin
            mem[bram_addrW] <= (corrupt && bram_addrW == 4'd7) ? (bram_din ^ 16'h0001) : bram_din;
        end
        rd_q <= mem[bram_addrR];
    end
    assign bram_dout = rd_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst && bram_wen) begin
            if (exp_wr.size() == 0) begin
                chk("wr_unexpected", {16'h0, bram_addrW, bram_din[11:0]}, 32'hFFFF_FFFF);
            end else begin
                wr_e = exp_wr.pop_front();
                chk("wr_addr", 32'(bram_addrW), 32'(wr_e[19:16]));
                chk("wr_data", 32'(bram_din), 32'(wr_e[15:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ld_ready", 32'(in_ready), 32'd1);
        chk("ld_busy", 32'(busy), 32'd1);
        chk("ld_done", 32'(done), 32'd0);
        chk("ld_pass", 32'(pass), 32'd0);
    endtask

    // in_valid is left high into VERIFY so a stray accepted beat would show up
    task automatic send(input bit gaps, input int start_beat);
        int i = 0;
        int cyc = 0;
        while (i < 16 && cyc < 100) begin
            if (gaps && cyc[0]) begin
                in_valid = 1'b0;
                in_data  = 16'hFFFF;
                start    = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = words[i];
                start    = (i == start_beat);
                exp_wr.push_back({4'(i), words[i]});
                i++;
            end
            cyc++;
            tick();
        end
        chk("send_bound", 32'(i), 32'd16);
        start   = 1'b0;
        in_data = 16'hDEAD;
    endtask

    task automatic verify_wait(input bit exp_pass);
        for (int k = 0; k <= 16; k++) begin
            chk("vf_busy", 32'(busy), 32'd1);
            chk("vf_done", 32'(done), 32'd0);
            chk("vf_ready", 32'(in_ready), 32'd0);
            chk("vf_addrR", 32'(bram_addrR), (k < 16) ? 32'(k) : 32'd0);
            tick();
            if (k == 0) in_valid = 1'b0;
        end
        chk("dn_done", 32'(done), 32'd1);
        chk("dn_busy", 32'(busy), 32'd0);
        chk("dn_pass", 32'(pass), 32'(exp_pass));
        chk("dn_addrR", 32'(bram_addrR), 32'd0);
        chk("dn_pending", 32'(exp_wr.size()), 32'd0);
        tick();
        tick();
        chk("dn_hold_done", 32'(done), 32'd1);
        chk("dn_hold_pass", 32'(pass), 32'(exp_pass));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_wen"}, 32'(bram_wen), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_addrW"}, 32'(bram_addrW), 32'd0);
        chk({tag, "_addrR"}, 32'(bram_addrR), 32'd0);
        chk({tag, "_din"}, 32'(bram_din), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        corrupt  = 1'b0;
        mem_clr  = 1'b0;
        #2;
        check_idle_outputs("rst");
        tick();
        tick();
        rst   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("first_start", 32'(in_ready), 32'd1);

        // back-to-back beats 0x0001..0x0010
        for (int i = 0; i < 16; i++) words[i] = 16'(i + 1);
        send(1'b0, -1);
        verify_wait(1'b1);
        for (int i = 0; i < 16; i++) chk("mem_b2b", 32'(mem[i]), 32'(i + 1));

        // same data with gaps every other cycle into a cleared memory
        mem_clr = 1'b1;
        tick();
        mem_clr = 1'b0;
        start_load();
        send(1'b1, -1);
        verify_wait(1'b1);
        for (int i = 0; i < 16; i++) chk("mem_gap", 32'(mem[i]), 32'(i + 1));

        // corrupted word at address 7
        corrupt = 1'b1;
        start_load();
        send(1'b0, -1);
        verify_wait(1'b0);
        corrupt = 1'b0;

        // start pulsed alongside beat 5
        start_load();
        send(1'b0, 5);
        verify_wait(1'b1);

        // reset after beat 9, then a fresh load of 0xA5A5
        start_load();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            exp_wr.push_back({4'(i), words[i]});
            tick();
        end
        rst = 1'b0;
        #1;
        check_idle_outputs("mid_rst");
        exp_wr.delete();
        in_valid = 1'b0;
        tick();
        chk("mid_rst_held_done", 32'(done), 32'd0);
        rst = 1'b1;
        tick();
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 16; i++) words[i] = 16'hA5A5;
        start_load();
        send(1'b0, -1);
        verify_wait(1'b1);

        // start from DONE clears done/pass and reloads
        for (int i = 0; i < 16; i++) words[i] = 16'(16'h1000 + i * 3);
        start_load();
        send(1'b0, -1);
        verify_wait(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
